// File: rtl/axisr_profiler_sampler_pkg.sv
// Shared profiler types: one sample record holds the three 64-bit counter deltas.
package lynxTypes;

    localparam int PROF_SAMPLE_BITS = 192;

    typedef struct packed {
        logic [63:0] stall;
        logic [63:0] pkt;
        logic [63:0] bytes;
    } prof_sample_t;

endpackage

// File: rtl/axisr_profiler_sampler_fifo.sv
// Synchronous sample-record FIFO; a pushed word is visible at the head on the following cycle.
module prof_sample_fifo #(
    parameter int WIDTH = 193,
    parameter int DEPTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axisr_profiler_sampler.sv
// Periodic sampler: clears the stream profiler, then emits per-interval counter deltas
// as AXI4-Stream records through a small FIFO.
module axisr_profiler_sampler
    import lynxTypes::*;
#(
    parameter int PERIOD_BITS = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int CLR_WAIT    = 2
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        ctrl_start,
    input  logic                        ctrl_stop,
    input  logic [PERIOD_BITS-1:0]      ctrl_period,
    input  logic [63:0]                 byte_cnt,
    input  logic [63:0]                 pkt_cnt,
    input  logic [63:0]                 ready_down,
    output logic                        prof_reset,
    output logic                        m_sample_tvalid,
    input  logic                        m_sample_tready,
    output logic [PROF_SAMPLE_BITS-1:0] m_sample_tdata,
    output logic                        m_sample_tlast,
    output logic                        busy,
    output logic [31:0]                 dropped_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_RUN} state_t;

    localparam int CW = $clog2(CLR_WAIT + 2);

    state_t                 state;
    state_t                 next_state;
    logic [CW-1:0]          clr_cnt;
    logic [PERIOD_BITS-1:0] period_q;
    logic [PERIOD_BITS-1:0] per_cnt;
    prof_sample_t           prev;
    prof_sample_t           cur;
    prof_sample_t           delta;
    logic                   start_ok;
    logic                   clr_done;
    logic                   fire;
    logic                   fire_last;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [PROF_SAMPLE_BITS:0] fifo_rd;

    assign cur         = '{stall: ready_down, pkt: pkt_cnt, bytes: byte_cnt};
    assign delta.bytes = cur.bytes - prev.bytes;
    assign delta.pkt   = cur.pkt   - prev.pkt;
    assign delta.stall = cur.stall - prev.stall;

    assign busy       = (state != ST_IDLE);
    assign prof_reset = (state == ST_CLEAR) && (clr_cnt == '0);

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= next_state;
    end

    // A stop always produces the final record, even when it lands on a period expiry.
    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        clr_done   = 1'b0;
        fire       = 1'b0;
        fire_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_start) begin
                    next_state = ST_CLEAR;
                    start_ok   = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == CW'(CLR_WAIT)) begin
                    next_state = ST_RUN;
                    clr_done   = 1'b1;
                end
            end
            ST_RUN: begin
                if (ctrl_stop) begin
                    fire       = 1'b1;
                    fire_last  = 1'b1;
                    next_state = ST_IDLE;
                end else if (per_cnt == '0) begin
                    fire = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            clr_cnt     <= '0;
            period_q    <= PERIOD_BITS'(1);
            per_cnt     <= '0;
            prev        <= '0;
            dropped_cnt <= '0;
        end else begin
            if (start_ok) begin
                period_q <= (ctrl_period == '0) ? PERIOD_BITS'(1) : ctrl_period;
                clr_cnt  <= '0;
            end else if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + CW'(1);
            end

            if (clr_done || fire) begin
                prev    <= cur;
                per_cnt <= period_q - PERIOD_BITS'(1);
            end else if (state == ST_RUN) begin
                per_cnt <= per_cnt - PERIOD_BITS'(1);
            end

            if (start_ok) begin
                dropped_cnt <= '0;
            end else if (fire && fifo_full && !pop && dropped_cnt != '1) begin
                dropped_cnt <= dropped_cnt + 32'd1;
            end
        end
    end

    assign pop = m_sample_tvalid && m_sample_tready;

    prof_sample_fifo #(
        .WIDTH (PROF_SAMPLE_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (fire),
        .push_data ({fire_last, delta}),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_sample_tvalid = !fifo_empty;
    assign m_sample_tdata  = fifo_rd[PROF_SAMPLE_BITS-1:0];
    assign m_sample_tlast  = fifo_rd[PROF_SAMPLE_BITS];

endmodule

// File: tb/tb_axisr_profiler_sampler.sv
// Bench for axisr_profiler_sampler: directed sessions plus random sessions checked
// against a schedule-based reference model with a queue standing in for the FIFO.
module tb_axisr_profiler_sampler;

    localparam int PERIOD_BITS = 32;
    localparam int DEPTH       = 16;
    localparam int CLR_WAIT    = 2;

    logic                   aclk;
    logic                   aresetn;
    logic                   ctrl_start;
    logic                   ctrl_stop;
    logic [PERIOD_BITS-1:0] ctrl_period;
    logic [63:0]            byte_cnt;
    logic [63:0]            pkt_cnt;
    logic [63:0]            ready_down;
    logic                   prof_reset;
    logic                   m_sample_tvalid;
    logic                   m_sample_tready;
    logic [191:0]           m_sample_tdata;
    logic                   m_sample_tlast;
    logic                   busy;
    logic [31:0]            dropped_cnt;

    axisr_profiler_sampler #(
        .PERIOD_BITS (PERIOD_BITS),
        .FIFO_DEPTH  (DEPTH),
        .CLR_WAIT    (CLR_WAIT)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .ctrl_start      (ctrl_start),
        .ctrl_stop       (ctrl_stop),
        .ctrl_period     (ctrl_period),
        .byte_cnt        (byte_cnt),
        .pkt_cnt         (pkt_cnt),
        .ready_down      (ready_down),
        .prof_reset      (prof_reset),
        .m_sample_tvalid (m_sample_tvalid),
        .m_sample_tready (m_sample_tready),
        .m_sample_tdata  (m_sample_tdata),
        .m_sample_tlast  (m_sample_tlast),
        .busy            (busy),
        .dropped_cnt     (dropped_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int           n_checks = 0;
    int           n_fails  = 0;
    int           phase    = 0;
    longint       cyc      = 0;

    // profiler stimulus shape
    logic [63:0]  byte_inc  = 64;
    logic         pkt_every4 = 1'b1;
    logic         stall_rand = 1'b0;

    // reference model: session schedule in absolute cycles plus an expected-record queue
    logic         m_active = 1'b0;
    longint       m_start  = 0;
    longint       m_period = 1;
    logic [63:0]  prev_b, prev_p, prev_s;
    logic [192:0] exp_q[$];
    logic [31:0]  exp_drop = 0;

    task automatic check1(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Advance one clock cycle, predicting what the edge does from the spec's rules.
    task automatic applyStimulus();
        logic         do_pop;
        logic         do_push;
        logic [192:0] rec;
        longint       base;
        do_pop  = (exp_q.size() != 0) && m_sample_tready;
        do_push = 1'b0;
        rec     = '0;
        base    = m_start + 1 + CLR_WAIT;
        if (!aresetn) begin
            m_active = 1'b0;
            exp_q.delete();
            exp_drop = 0;
        end else begin
            if (!m_active) begin
                if (ctrl_start) begin
                    m_active = 1'b1;
                    m_start  = cyc;
                    m_period = (ctrl_period == 0) ? 1 : longint'(ctrl_period);
                    exp_drop = 0;
                end
            end else if (cyc == base) begin
                prev_b = byte_cnt; prev_p = pkt_cnt; prev_s = ready_down;
            end else if (cyc > base && (ctrl_stop || ((cyc - base) % m_period) == 0)) begin
                rec     = {ctrl_stop, ready_down - prev_s, pkt_cnt - prev_p, byte_cnt - prev_b};
                do_push = 1'b1;
                prev_b = byte_cnt; prev_p = pkt_cnt; prev_s = ready_down;
                if (ctrl_stop) m_active = 1'b0;
            end
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                if (exp_q.size() < DEPTH)      exp_q.push_back(rec);
                else if (exp_drop != '1)       exp_drop = exp_drop + 1;
            end
        end
        @(posedge aclk);
        #1;
        cyc++;
        byte_cnt = byte_cnt + byte_inc;
        if (pkt_every4) pkt_cnt = pkt_cnt + ((cyc % 4 == 0) ? 64'd1 : 64'd0);
        else            pkt_cnt = pkt_cnt + 64'($urandom_range(0, 3));
        if (stall_rand) ready_down = ready_down + 64'($urandom_range(0, 1));
    endtask

    task automatic checkOutput();
        check1("tvalid", m_sample_tvalid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check1("tdata", m_sample_tdata, exp_q[0][191:0]);
            check1("tlast", m_sample_tlast, exp_q[0][192]);
        end
        check1("busy", busy, m_active);
        check1("prof_reset", prof_reset, m_active && (cyc == m_start + 1));
        check1("dropped_cnt", dropped_cnt, exp_drop);
        if (phase == 2 && m_sample_tvalid && !m_sample_tlast) begin
            check1("t2_byte_delta", m_sample_tdata[63:0], 64'd6400);
            check1("t2_pkt_delta", m_sample_tdata[127:64], 64'd25);
            check1("t2_stall_delta", m_sample_tdata[191:128], 64'd0);
        end
        if (phase == 3 && m_sample_tvalid)
            check1("t3_wrap_delta", m_sample_tdata[63:0], 64'd64);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            checkOutput();
        end
    endtask

    task automatic start_session(input logic [PERIOD_BITS-1:0] p);
        ctrl_period = p;
        ctrl_start  = 1'b1;
        run(1);
        ctrl_start  = 1'b0;
    endtask

    task automatic stop_session();
        ctrl_stop = 1'b1;
        run(1);
        ctrl_stop = 1'b0;
    endtask

    task automatic drain();
        m_sample_tready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) run(1);
        run(1);
        check1("drain_empty", m_sample_tvalid, 1'b0);
    endtask

    initial begin
        longint s;
        aresetn = 1'b0; ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_period = 100;
        byte_cnt = 64'h1000; pkt_cnt = 0; ready_down = 0; m_sample_tready = 1'b1;
        prev_b = 0; prev_p = 0; prev_s = 0;

        // 1: reset and idle
        phase = 1;
        run(3);
        aresetn = 1'b1;
        run(8);

        // 2: period 100, steady ramps
        phase = 2;
        byte_inc = 64; pkt_every4 = 1'b1; stall_rand = 1'b0;
        start_session(100);
        run(350);
        stop_session();
        drain();

        // 3: byte counter wraps, period 1
        phase = 3;
        byte_cnt = 64'hFFFF_FFFF_FFFF_FFF6;
        start_session(1);
        run(12);
        stop_session();
        drain();

        // 4: stalled output, 20 samples into a 16-deep FIFO
        phase = 4;
        byte_inc = 64'($urandom_range(1, 1000)); pkt_every4 = 1'b0;
        m_sample_tready = 1'b0;
        s = cyc;
        start_session(1);
        while (cyc < s + 3 + 20) run(1);
        stop_session();
        check1("t4_dropped", dropped_cnt, 32'd4);
        check1("t4_full_valid", m_sample_tvalid, 1'b1);
        m_sample_tready = 1'b1;
        run(DEPTH + 1);
        check1("t4_empty", m_sample_tvalid, 1'b0);

        // 5: stop exactly on a period expiry
        phase = 5;
        s = cyc;
        start_session(5);
        while (cyc < s + 3 + 10) run(1);
        stop_session();
        check1("t5_busy", busy, 1'b0);
        check1("t5_last", m_sample_tlast, 1'b1);
        run(1);
        check1("t5_single", m_sample_tvalid, 1'b0);

        // 6: period 0, start while running, reset mid-session
        phase = 6;
        stall_rand = 1'b1;
        start_session(0);
        run(6);
        m_sample_tready = 1'b0;
        start_session(7);
        run(8);
        aresetn = 1'b0;
        run(1);
        check1("t6_rst_valid", m_sample_tvalid, 1'b0);
        check1("t6_rst_busy", busy, 1'b0);
        aresetn = 1'b1;
        m_sample_tready = 1'b1;
        run(5);

        // random sessions
        phase = 7;
        for (int k = 0; k < 8; k++) begin
            byte_inc = 64'($urandom);
            start_session(PERIOD_BITS'($urandom_range(0, 6)));
            for (int i = 0; i < int'($urandom_range(4, 60)); i++) begin
                m_sample_tready = ($urandom_range(0, 3) != 0);
                run(1);
            end
            stop_session();
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
